router_pkt_fifo: RTL and testbench

//  Parametrised, packet-aware output FIFO for one router destination port (one instance per port).

---
 rtl/router_pkt_fifo_pkg.sv | 14 +
 rtl/router_pkt_fifo_timer.sv | 22 ++
 rtl/router_pkt_fifo.sv | 101 ++++++++++
 tb/tb_router_pkt_fifo.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/router_pkt_fifo_pkg.sv
// router_pkt_fifo_pkg: shared defaults, header field layout and clog2 helper for the router FIFO.
package router_pkt_fifo_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int HDR_LEN_LSB    = 2;
   localparam int HDR_LEN_W      = 6;

   function automatic int clog2(input int n);
      int r;
      for (r = 0; (1 << r) < n; r++) begin
      end
      return r;
   endfunction
endpackage

// File: rtl/router_pkt_fifo_timer.sv
// router_fifo_timer: counts idle non-empty cycles; expire is high once the count reaches TIMEOUT-1.
module router_fifo_timer
   import router_pkt_fifo_pkg::*;
#(
   parameter int TIMEOUT = 30
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic expire
);
   localparam int TW = clog2(TIMEOUT);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb cnt_d = clr ? '0 : inc ? cnt_q + TW'(1) : cnt_q;

   always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;

   assign expire = cnt_q == TW'(TIMEOUT - 1);
endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: packet-aware output FIFO for one router port with header-driven length tracking,
// sticky overflow, and flush on soft_reset or read timeout.
module router_pkt_fifo
   import router_pkt_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int LEN_LSB    = HDR_LEN_LSB,
   parameter int LEN_W      = HDR_LEN_W,
   parameter int AF_THRESH  = 14,
   parameter int TIMEOUT    = 30,
   localparam int AW        = clog2(DEPTH)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  soft_reset,
   input  logic                  write_enb,
   input  logic                  read_enb,
   input  logic                  lfd_state,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic [AW:0]           level,
   output logic                  pkt_done,
   output logic                  timeout_flush,
   output logic                  overflow
);
   logic [DATA_WIDTH:0]   mem_q [DEPTH];
   logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
   logic [LEN_W:0]        rd_cnt_q, rd_cnt_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d, pkt_done_q, pkt_done_d, overflow_q, overflow_d;
   logic                  expire, flush, wr_acc, rd_acc, rd_tag;
   logic [DATA_WIDTH:0]   rd_word;

   assign full  = level_q == (AW + 1)'(DEPTH);
   assign empty = level_q == '0;

   always_comb begin
      flush        = soft_reset | expire;
      wr_acc       = write_enb & ~full & ~flush;
      rd_acc       = read_enb & ~empty & ~flush;
      rd_word      = mem_q[rd_ptr_q[AW-1:0]];
      rd_tag       = rd_word[DATA_WIDTH];
      wr_ptr_d     = flush ? '0 : wr_ptr_q + (AW + 1)'(wr_acc);
      rd_ptr_d     = flush ? '0 : rd_ptr_q + (AW + 1)'(rd_acc);
      level_d      = flush ? '0 : level_q + (AW + 1)'(wr_acc) - (AW + 1)'(rd_acc);
      data_out_d   = rd_acc ? rd_word[DATA_WIDTH-1:0] : data_out_q;
      data_valid_d = rd_acc;
      pkt_done_d   = rd_acc & ~rd_tag & (rd_cnt_q == (LEN_W + 1)'(1));
      // header reload counts payload plus the trailing parity word; stray untagged reads stop at 0
      rd_cnt_d     = flush   ? '0 :
                     !rd_acc ? rd_cnt_q :
                     rd_tag  ? (LEN_W + 1)'(rd_word[LEN_LSB +: LEN_W]) + (LEN_W + 1)'(1) :
                               rd_cnt_q - (LEN_W + 1)'(rd_cnt_q != '0);
      overflow_d   = overflow_q | (write_enb & full);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         rd_cnt_q     <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         pkt_done_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         rd_cnt_q     <= rd_cnt_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         pkt_done_q   <= pkt_done_d;
         overflow_q   <= overflow_d;
      end
   end

   always_ff @(posedge clock) if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};

   router_fifo_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clock (clock),
      .reset (reset),
      .clr   (empty | rd_acc | flush),
      .inc   (~empty & ~read_enb),
      .expire(expire)
   );

   assign data_out      = data_out_q;
   assign data_valid    = data_valid_q;
   assign level         = level_q;
   assign almost_full   = level_q >= (AW + 1)'(AF_THRESH);
   assign pkt_done      = pkt_done_q;
   assign timeout_flush = expire;
   assign overflow      = overflow_q;
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: directed checks of the router packet FIFO (default 8x16 and a 16-bit x 8 instance).
module tb_router_pkt_fifo;
   logic        clock = 1'b0;
   logic        reset, soft_reset, write_enb, read_enb, lfd_state;
   logic [7:0]  data_in, data_out;
   logic        data_valid, full, empty, almost_full, pkt_done, timeout_flush, overflow;
   logic [4:0]  level;
   logic        w_write_enb, w_read_enb;
   logic [15:0] w_data_in, w_data_out;
   logic        w_data_valid, w_full, w_empty, w_almost_full, w_pkt_done, w_timeout_flush, w_overflow;
   logic [3:0]  w_level;
   int          n_chk = 0, n_pass = 0;

   always #5 clock = ~clock;

   router_pkt_fifo u_dut (
      .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(write_enb),
      .read_enb(read_enb), .lfd_state(lfd_state), .data_in(data_in), .data_out(data_out),
      .data_valid(data_valid), .full(full), .empty(empty), .almost_full(almost_full),
      .level(level), .pkt_done(pkt_done), .timeout_flush(timeout_flush), .overflow(overflow)
   );

   router_pkt_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(6)) u_wide (
      .clock(clock), .reset(reset), .soft_reset(soft_reset), .write_enb(w_write_enb),
      .read_enb(w_read_enb), .lfd_state(1'b0), .data_in(w_data_in), .data_out(w_data_out),
      .data_valid(w_data_valid), .full(w_full), .empty(w_empty), .almost_full(w_almost_full),
      .level(w_level), .pkt_done(w_pkt_done), .timeout_flush(w_timeout_flush), .overflow(w_overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [7:0] d, input logic h);
      write_enb = 1'b1;
      lfd_state = h;
      data_in   = d;
      tick();
      write_enb = 1'b0;
      lfd_state = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [7:0] d, input logic done);
      read_enb = 1'b1;
      tick();
      read_enb = 1'b0;
      check({tag, "_data"}, data_out, d);
      check({tag, "_done"}, pkt_done, done);
   endtask

   initial begin
      logic [7:0] exp1 [16];
      int t;
      {soft_reset, write_enb, read_enb, lfd_state, w_write_enb, w_read_enb} = '0;
      data_in   = '0;
      w_data_in = '0;
      reset     = 1'b1;
      tick();
      tick();
      check("rst_empty", empty, 1);
      check("rst_level", level, 0);
      check("rst_flags", {full, almost_full, data_valid, pkt_done, timeout_flush, overflow}, 0);
      check("rst_dout", data_out, 0);
      reset = 1'b0;

      // header 0x38 carries length 14 -> 14 payload words then parity
      exp1[0] = 8'h38;
      for (int i = 1; i < 15; i++) exp1[i] = 8'h10 + 8'(i);
      exp1[15] = 8'hEE;
      for (int i = 0; i < 16; i++) wr(exp1[i], i == 0);
      check("t1_level", level, 16);
      check("t1_full", {full, almost_full}, 2'b11);
      read_enb = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check($sformatf("t1_rd%0d", i), {data_valid, pkt_done, data_out}, {1'b1, i == 15, exp1[i]});
      end
      read_enb = 1'b0;
      tick();
      check("t1_idle", {data_valid, pkt_done, empty}, 3'b001);

      for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
      wr(8'hAA, 1'b0);
      check("t2_ovf", {overflow, level}, {1'b1, 5'd16});
      rd("t2_rd0", 8'h00, 1'b0);
      check("t2_lvl", {full, almost_full, overflow, level}, {3'b011, 5'd15});
      for (int i = 1; i < 16; i++) rd($sformatf("t2_rd%0d", i), 8'(i), 1'b0);
      check("t2_empty", empty, 1);

      for (int i = 0; i < 8; i++) wr(8'h40 + 8'(i), 1'b0);
      for (int i = 0; i < 5; i++) begin
         {write_enb, read_enb} = 2'b11;
         data_in = 8'h50 + 8'(i);
         tick();
         check($sformatf("t3_rw%0d", i), {level, data_out}, {5'd8, 8'h40 + 8'(i)});
      end
      {write_enb, read_enb} = 2'b00;
      for (int i = 5; i < 8; i++) rd($sformatf("t3_a%0d", i), 8'h40 + 8'(i), 1'b0);
      for (int i = 0; i < 5; i++) rd($sformatf("t3_b%0d", i), 8'h50 + 8'(i), 1'b0);

      for (int i = 0; i < 3; i++) wr(8'h20 + 8'(i), 1'b0);
      t = 0;
      while (!timeout_flush && t < 40) begin
         tick();
         t++;
      end
      check("t4_wait", t, 27);
      check("t4_pre_lvl", level, 3);
      tick();
      check("t4_flushed", {empty, timeout_flush, level}, {2'b10, 5'd0});
      check("t4_keep", {overflow, data_out}, {1'b1, 8'h54});

      wr(8'h0C, 1'b1);
      wr(8'h61, 1'b0);
      rd("t5_hdr", 8'h0C, 1'b0);
      {soft_reset, write_enb} = 2'b11;
      data_in = 8'h62;
      tick();
      {soft_reset, write_enb} = 2'b00;
      check("t5_flush", {empty, level}, {1'b1, 5'd0});
      check("t5_keep", data_out, 8'h0C);
      wr(8'h04, 1'b1);
      check("t5_lvl1", level, 1);
      wr(8'h71, 1'b0);
      wr(8'h72, 1'b0);
      rd("t5_h", 8'h04, 1'b0);
      rd("t5_p", 8'h71, 1'b0);
      rd("t5_par", 8'h72, 1'b1);
      tick();
      check("t5_pulse", pkt_done, 0);

      for (int p = 0; p < 3; p++) begin
         w_write_enb = 1'b1;
         for (int i = 0; i < 8; i++) begin
            w_data_in = 16'hA000 + 16'(p * 16 + i);
            tick();
         end
         w_write_enb = 1'b0;
         check($sformatf("t6_full%0d", p), {w_full, w_almost_full, w_level}, {2'b11, 4'd8});
         w_read_enb = 1'b1;
         for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t6_p%0d_%0d", p, i), {w_data_valid, w_data_out}, {1'b1, 16'hA000 + 16'(p * 16 + i)});
         end
         w_read_enb = 1'b0;
         tick();
         check($sformatf("t6_empty%0d", p), {w_empty, w_data_valid, w_level}, {2'b10, 4'd0});
      end
      check("t6_flags", {w_overflow, w_pkt_done, w_timeout_flush}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
